// File: rtl/cpu_pkg.sv
// Shared datapath constants and the multiply/divide responder state type.
package cpu_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned CPU_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MULT   = 3'd1,
    DIV    = 3'd2,
    FIX    = 3'd3,
    FINISH = 3'd4
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Restoring unsigned divider on operand magnitudes: one quotient bit per step.
module div_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned CNT_W = CPU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend_mag,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_c
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    shifted_c = {rem_q, quo_q[WIDTH-1]};
    trial_c   = shifted_c - {1'b0, dsr_q};
    if (load) begin
      quo_d = dividend_mag;
      rem_d = '0;
      dsr_d = divisor_mag;
      cnt_d = '0;
    end else if (step) begin
      if (shifted_c >= {1'b0, dsr_q}) begin
        rem_d = trial_c[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted_c[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last_c    = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) responder with done pulse.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned CNT_W = CPU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned PW = 2 * WIDTH + 1;

  md_state_t        state_q, state_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             div_load_c, div_step_c, div_last_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, quo_c, rem_c, fix_quo_c, fix_rem_c;
  logic [WIDTH:0]   acc_ext_c, mcand_ext_c, booth_sum_c;
  logic [PW-1:0]    booth_next_c;

  assign a_mag_c   = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
  assign b_mag_c   = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
  assign fix_quo_c = q_neg_q ? (~quo_c + WIDTH'(1)) : quo_c;
  assign fix_rem_c = r_neg_q ? (~rem_c + WIDTH'(1)) : rem_c;

  // Booth step uses a WIDTH+1 accumulator so that subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    acc_ext_c   = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
    mcand_ext_c = {mcand_q[WIDTH-1], mcand_q};
    case (prod_q[1:0])
      2'b01:   booth_sum_c = acc_ext_c + mcand_ext_c;
      2'b10:   booth_sum_c = acc_ext_c - mcand_ext_c;
      default: booth_sum_c = acc_ext_c;
    endcase
    booth_next_c = {booth_sum_c, prod_q[WIDTH:1]};
  end

  div_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_div_core (
    .clk         (clk),
    .reset       (reset),
    .load        (div_load_c),
    .step        (div_step_c),
    .dividend_mag(a_mag_c),
    .divisor_mag (b_mag_c),
    .quotient    (quo_c),
    .remainder   (rem_c),
    .last_c      (div_last_c)
  );

  always_comb begin
    state_d    = state_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mcnt_d     = mcnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    div_load_c = 1'b0;
    div_step_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mult_start) begin
          mcand_d    = op_a;
          prod_d     = {{WIDTH{1'b0}}, op_b, 1'b0};
          mcnt_d     = '0;
          dz_d       = 1'b0;
          div_zero_d = 1'b0;
          state_d    = MULT;
        end else if (div_start) begin
          div_zero_d = 1'b0;
          if (op_b == '0) begin
            dz_d    = 1'b1;
            state_d = FINISH;
          end else begin
            dz_d       = 1'b0;
            div_load_c = 1'b1;
            q_neg_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_neg_d    = op_a[WIDTH-1];
            state_d    = DIV;
          end
        end
      end
      MULT: begin
        prod_d = booth_next_c;
        mcnt_d = mcnt_q + CNT_W'(1);
        if (mcnt_q == CNT_W'(WIDTH - 1)) state_d = FINISH;
      end
      DIV: begin
        div_step_c = 1'b1;
        if (div_last_c) state_d = FIX;
      end
      FIX: begin
        // Signed results reuse the product register so FINISH has a single source.
        prod_d  = {fix_rem_c, fix_quo_c, 1'b0};
        state_d = FINISH;
      end
      FINISH: begin
        done_d = 1'b1;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else begin
          hi_d = prod_q[PW-1:WIDTH+1];
          lo_d = prod_q[WIDTH:1];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prod_q     <= '0;
      mcand_q    <= '0;
      mcnt_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mcnt_q     <= mcnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
